// File: rtl/pcecd_cmd_collector.sv
// pcecd_cmd_collector
// Target-side COMMAND phase byte collector for the PCE CD drive. Runs the
// REQ/ACK handshake, captures the CDB into a small buffer, sizes the CDB from
// the opcode group and holds the finished command until the phase FSM takes it.

module pcecd_cmd_collector #(
    parameter int MAX_CDB = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_phase,
    input  logic       i_bus_rst,
    input  logic       i_ack,
    input  logic [7:0] i_db,
    input  logic       i_cmd_ack,
    input  logic [3:0] i_rd_idx,
    output logic       o_req,
    output logic       o_cmd_valid,
    output logic [7:0] o_opcode,
    output logic [3:0] o_cmd_len,
    output logic       o_bad_opcode,
    output logic [7:0] o_rd_data,
    output logic       o_abort
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_HI = 2'd1,
        ST_ACK_LO = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LP_MAX    = 4'(MAX_CDB);
    localparam logic [3:0] LP_LEN_6  = 4'd6;
    localparam logic [3:0] LP_LEN_10 = 4'd10;

    // FSM and handshake state
    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_count;
    logic [3:0] w_count_nxt;
    logic       r_armed;
    logic       r_req;
    logic       r_cmd_valid;
    logic       r_abort;

    // Captured command
    logic [7:0] r_opcode;
    logic [3:0] r_cmd_len;
    logic       r_bad_opcode;
    logic [3:0] r_exp_len;
    logic       r_exp_bad;
    logic [7:0] r_buf [MAX_CDB];

    // Per-cycle control strobes from the FSM
    logic       w_wr_en;
    logic       w_abort;
    logic       w_done;
    logic       w_release;
    logic       w_disarm;
    logic       w_cut;

    // Opcode group decode of the byte currently on the bus
    logic [3:0] w_grp_len;
    logic       w_grp_bad;

    // Collection is cut short by a bus reset or by leaving COMMAND phase
    assign w_cut = i_bus_rst || !i_cmd_phase;

    // Length class of an opcode: group 0 is 6 bytes, groups 1/2/6 are 10 bytes
    always_comb begin
        // NOTE: every combinational output gets a default first so that no path
        // through the case leaves it unassigned and infers a latch.
        w_grp_len = 4'd0;
        w_grp_bad = 1'b0;
        case (i_db[7:5])
            3'd0:             w_grp_len = LP_LEN_6;
            3'd1, 3'd2, 3'd6: w_grp_len = LP_LEN_10;
            default:          w_grp_bad = 1'b1;
        endcase
    end

    // Next-state and control strobes for the REQ/ACK handshake
    always_comb begin
        w_next_state = r_state;
        w_count_nxt  = r_count;
        w_wr_en      = 1'b0;
        w_abort      = 1'b0;
        w_done       = 1'b0;
        w_release    = 1'b0;
        w_disarm     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A bus reset only blocks entry; armed gates re-collection
                if (r_armed && i_cmd_phase && !i_bus_rst) begin
                    w_next_state = ST_REQ_HI;
                    w_count_nxt  = 4'd0;
                end
            end
            ST_REQ_HI: begin
                if (w_cut) begin
                    w_next_state = ST_IDLE;
                    w_count_nxt  = 4'd0;
                    w_abort      = 1'b1;
                end else if (i_ack) begin
                    // ACK may already be high on entry; level-sensitive capture
                    w_wr_en      = 1'b1;
                    w_count_nxt  = (r_count >= LP_MAX) ? r_count : r_count + 4'd1;
                    w_next_state = ST_ACK_LO;
                end
            end
            ST_ACK_LO: begin
                if (w_cut) begin
                    w_next_state = ST_IDLE;
                    w_count_nxt  = 4'd0;
                    w_abort      = 1'b1;
                end else if (!i_ack) begin
                    if (r_exp_bad || (r_count == r_exp_len)) begin
                        w_next_state = ST_DONE;
                        w_done       = 1'b1;
                    end else begin
                        w_next_state = ST_REQ_HI;
                    end
                end
            end
            ST_DONE: begin
                if (i_bus_rst) begin
                    w_next_state = ST_IDLE;
                    w_release    = 1'b1;
                end else if (i_cmd_ack) begin
                    w_next_state = ST_IDLE;
                    w_release    = 1'b1;
                    w_disarm     = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_count_nxt  = 4'd0;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte counter, registered handshake/status strobes and the re-arm flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= 4'd0;
            r_req       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_abort     <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_count     <= w_count_nxt;
            r_req       <= (w_next_state == ST_REQ_HI);
            r_cmd_valid <= (w_next_state == ST_DONE);
            r_abort     <= w_abort;
            // Leaving COMMAND phase re-arms; consuming a command disarms
            if (!i_cmd_phase) begin
                r_armed <= 1'b1;
            end else if (w_disarm) begin
                r_armed <= 1'b0;
            end
        end
    end

    // Opcode capture, expected length and the reported command result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opcode     <= 8'h00;
            r_exp_len    <= 4'd0;
            r_exp_bad    <= 1'b0;
            r_cmd_len    <= 4'd0;
            r_bad_opcode <= 1'b0;
        end else begin
            if (w_wr_en && (r_count == 4'd0)) begin
                r_opcode  <= i_db;
                r_exp_len <= w_grp_len;
                r_exp_bad <= w_grp_bad;
            end
            if (w_done) begin
                r_cmd_len    <= r_exp_bad ? 4'd1 : r_count;
                r_bad_opcode <= r_exp_bad;
            end else if (w_release) begin
                r_bad_opcode <= 1'b0;
            end
        end
    end

    // CDB byte buffer; left untouched by aborts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: this buffer is small and must read back as 0x00 after reset,
        // so it is built from resettable flops rather than a RAM.
        if (!i_rst_n) begin
            for (int i = 0; i < MAX_CDB; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_wr_en && (r_count < LP_MAX)) begin
            r_buf[r_count] <= i_db;
        end
    end

    assign o_req        = r_req;
    assign o_cmd_valid  = r_cmd_valid;
    assign o_opcode     = r_opcode;
    assign o_cmd_len    = r_cmd_len;
    assign o_bad_opcode = r_bad_opcode;
    assign o_abort      = r_abort;
    assign o_rd_data    = (i_rd_idx < LP_MAX) ? r_buf[i_rd_idx] : 8'h00;

endmodule

// File: tb/tb_pcecd_cmd_collector.sv
// Directed testbench for pcecd_cmd_collector. Inputs change and outputs are
// sampled on the falling clock edge; the design acts on the rising edge.

module tb_pcecd_cmd_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_phase;
    logic       bus_rst;
    logic       ack;
    logic [7:0] db;
    logic       cmd_ack;
    logic [3:0] rd_idx;
    logic       o_req;
    logic       o_cmd_valid;
    logic [7:0] o_opcode;
    logic [3:0] o_cmd_len;
    logic       o_bad_opcode;
    logic [7:0] o_rd_data;
    logic       o_abort;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         req_rises = 0;
    int         base;
    logic       req_q     = 1'b0;
    logic [7:0] cmd [10];

    pcecd_cmd_collector #(.MAX_CDB(10)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_phase  (cmd_phase),
        .i_bus_rst    (bus_rst),
        .i_ack        (ack),
        .i_db         (db),
        .i_cmd_ack    (cmd_ack),
        .i_rd_idx     (rd_idx),
        .o_req        (o_req),
        .o_cmd_valid  (o_cmd_valid),
        .o_opcode     (o_opcode),
        .o_cmd_len    (o_cmd_len),
        .o_bad_opcode (o_bad_opcode),
        .o_rd_data    (o_rd_data),
        .o_abort      (o_abort)
    );

    always #5 clk = ~clk;

    // Count REQ rising edges as seen by the initiator
    always @(negedge clk) begin
        if (o_req === 1'b1 && req_q !== 1'b1) req_rises++;
        req_q = o_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for the target to raise REQ
    task automatic wait_req();
        int cyc = 0;
        while (o_req !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (o_req !== 1'b1) check("req_timeout", 32'(o_req), 32'd1);
    endtask

    // Initiator side: answer n REQs with the bytes in cmd[]
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            wait_req();
            if (o_req !== 1'b1) return;
            db  = cmd[i];
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            @(negedge clk);
        end
        db = 8'h00;
    endtask

    task automatic pulse_cmd_ack();
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
    endtask

    // Drop the phase for one cycle (re-arms), then re-enter COMMAND phase
    task automatic phase_cycle();
        cmd_phase = 1'b0;
        @(negedge clk);
        cmd_phase = 1'b1;
    endtask

    task automatic read_buf(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        rd_idx = idx;
        #1;
        check(tag, 32'(o_rd_data), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; cmd_phase = 1'b0; bus_rst = 1'b0; ack = 1'b0;
        cmd_ack = 1'b0; db = 8'h00; rd_idx = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(o_req),        32'd0);
        check("rst_valid", 32'(o_cmd_valid),  32'd0);
        check("rst_op",    32'(o_opcode),     32'd0);
        check("rst_len",   32'(o_cmd_len),    32'd0);
        check("rst_bad",   32'(o_bad_opcode), 32'd0);
        check("rst_abort", 32'(o_abort),      32'd0);
        check("rst_rd",    32'(o_rd_data),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // READ(6)
        base = req_rises;
        cmd_phase = 1'b1;
        @(negedge clk);
        check("t1_req_latency", 32'(o_req), 32'd1);
        cmd = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(6);
        check("t1_req_count", 32'(req_rises - base), 32'd6);
        check("t1_valid",     32'(o_cmd_valid),      32'd1);
        check("t1_opcode",    32'(o_opcode),         32'h08);
        check("t1_len",       32'(o_cmd_len),        32'd6);
        check("t1_bad",       32'(o_bad_opcode),     32'd0);
        read_buf("t1_buf3", 4'd3, 8'h10);
        repeat (3) @(negedge clk);
        check("t1_hold", 32'(o_cmd_valid), 32'd1);
        pulse_cmd_ack();
        check("t1_valid_clr", 32'(o_cmd_valid), 32'd0);
        repeat (5) @(negedge clk);
        check("t1_no_rearm", 32'(req_rises - base), 32'd6);
        check("t1_req_low",  32'(o_req),            32'd0);

        // Vendor 10-byte command, group 6
        phase_cycle();
        base = req_rises;
        cmd = '{8'hD8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        send_bytes(10);
        check("t2_req_count", 32'(req_rises - base), 32'd10);
        check("t2_valid",     32'(o_cmd_valid),      32'd1);
        check("t2_opcode",    32'(o_opcode),         32'hD8);
        check("t2_len",       32'(o_cmd_len),        32'd10);
        check("t2_bad",       32'(o_bad_opcode),     32'd0);
        read_buf("t2_buf9",  4'd9,  8'h80);
        read_buf("t2_buf12", 4'd12, 8'h00);
        read_buf("t2_buf3",  4'd3,  8'h00);
        pulse_cmd_ack();

        // Unsupported opcode group
        phase_cycle();
        base = req_rises;
        cmd[0] = 8'hA5;
        send_bytes(1);
        check("t3_valid",  32'(o_cmd_valid),  32'd1);
        check("t3_bad",    32'(o_bad_opcode), 32'd1);
        check("t3_len",    32'(o_cmd_len),    32'd1);
        check("t3_opcode", 32'(o_opcode),     32'hA5);
        repeat (3) @(negedge clk);
        check("t3_one_req", 32'(req_rises - base), 32'd1);
        pulse_cmd_ack();
        check("t3_valid_clr", 32'(o_cmd_valid),  32'd0);
        check("t3_bad_clr",   32'(o_bad_opcode), 32'd0);

        // Phase drop after 3 of 6 bytes, then a clean restart
        phase_cycle();
        cmd = '{8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(3);
        check("t4_req4", 32'(o_req), 32'd1);
        cmd_phase = 1'b0;
        @(negedge clk);
        check("t4_req_drop", 32'(o_req),   32'd0);
        check("t4_abort",    32'(o_abort), 32'd1);
        @(negedge clk);
        check("t4_abort_1cyc", 32'(o_abort),     32'd0);
        check("t4_no_valid",   32'(o_cmd_valid), 32'd0);
        cmd_phase = 1'b1;
        base = req_rises;
        send_bytes(6);
        check("t4_req_count", 32'(req_rises - base), 32'd6);
        check("t4_valid",     32'(o_cmd_valid),      32'd1);
        check("t4_len",       32'(o_cmd_len),        32'd6);
        read_buf("t4_buf0", 4'd0, 8'h08);
        read_buf("t4_buf1", 4'd1, 8'h11);
        read_buf("t4_buf5", 4'd5, 8'h55);
        pulse_cmd_ack();

        // Bus reset during REQ_HI, then during DONE
        phase_cycle();
        wait_req();
        bus_rst = 1'b1;
        @(negedge clk);
        bus_rst = 1'b0;
        check("t5_req_drop", 32'(o_req),   32'd0);
        check("t5_abort",    32'(o_abort), 32'd1);
        @(negedge clk);
        check("t5_abort_1cyc", 32'(o_abort), 32'd0);
        cmd = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(6);
        check("t5_valid", 32'(o_cmd_valid), 32'd1);
        bus_rst = 1'b1;
        @(negedge clk);
        bus_rst = 1'b0;
        cmd_phase = 1'b0;
        check("t5_done_clr",  32'(o_cmd_valid), 32'd0);
        check("t5_no_abort",  32'(o_abort),     32'd0);
        @(negedge clk);
        check("t5_no_abort2", 32'(o_abort),     32'd0);

        // Asynchronous reset while REQ is high
        cmd_phase = 1'b1;
        wait_req();
        read_buf("t6_buf3_pre", 4'd3, 8'h10);
        check("t6_op_pre", 32'(o_opcode), 32'h08);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req",   32'(o_req),        32'd0);
        check("t6_valid", 32'(o_cmd_valid),  32'd0);
        check("t6_op",    32'(o_opcode),     32'd0);
        check("t6_len",   32'(o_cmd_len),    32'd0);
        check("t6_abort", 32'(o_abort),      32'd0);
        check("t6_rd",    32'(o_rd_data),    32'd0);
        cmd_phase = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
